// File: rtl/vga_bus_responder_if.sv
// ---------------------------------------------------------------------------
// vga_bus_responder_if
//   Request/grant bus between a bus initiator and the VGA bus responder.
//
//   Signals:
//     bus_req   initiator -> responder  request; dropping it during grant
//                                       marks the address cycle
//     bus_in    initiator -> responder  32-bit address, sampled in the
//                                       address cycle
//     bus_ack   responder -> initiator  grant, high only while granted
//     bus_wait  responder -> initiator  read data not ready yet
//     bus_data  responder -> initiator  read data, 0 when not driven
//     bus_drive responder -> initiator  bus_data is valid and driven
//
//   Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface vga_bus_responder_if;
    logic        bus_req;
    logic [31:0] bus_in;
    logic        bus_ack;
    logic        bus_wait;
    logic [31:0] bus_data;
    logic        bus_drive;

    modport master (
        output bus_req,
        output bus_in,
        input  bus_ack,
        input  bus_wait,
        input  bus_data,
        input  bus_drive
    );

    modport slave (
        input  bus_req,
        input  bus_in,
        output bus_ack,
        output bus_wait,
        output bus_data,
        output bus_drive
    );
endinterface

// File: rtl/vga_bus_responder.sv
// ---------------------------------------------------------------------------
// vga_bus_responder
//   Answers single-word reads from a bus initiator out of a word-addressed
//   video memory. Out-of-range addresses and memory timeouts complete with
//   32'hDEADBEEF and set a sticky error flag.
//
//   Handshake: the initiator raises bus_req; the responder answers with
//   bus_ack (GRANT). The cycle in which bus_req is seen low while bus_ack is
//   high is the address cycle: bus_in is sampled and the memory read issued.
//   bus_wait then stays high until data is available, after which bus_data is
//   driven (bus_drive=1) for exactly two cycles. bus_req is ignored from the
//   address cycle until the responder is back in IDLE.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous active-low reset
//     bus        slave modport of vga_bus_responder_if
//     mem_re     one-cycle memory read strobe
//     mem_addr   memory word address
//     mem_rdata  memory read data
//     mem_rvalid mem_rdata valid this cycle
//     err        sticky error flag
//     err_clr    clears err (a simultaneous set wins)
//     dbg_state  current FSM state encoding
// ---------------------------------------------------------------------------
module vga_bus_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h00001050,
    parameter int unsigned MEM_WORDS    = 19200,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    vga_bus_responder_if.slave          bus,
    output logic                        mem_re,
    output logic [15:0]                 mem_addr,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        err,
    input  logic                        err_clr,
    output logic [2:0]                  dbg_state
);

    localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_WAIT  = 3'd2,
        S_DATA  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        have_data;
    logic        err_txn;     // current transaction ends in an error response
    logic [7:0]  wait_cnt;
    logic [31:0] data_q;
    logic [15:0] addr_q;

    logic [31:0] off;
    logic        in_range;
    logic        addr_cycle;
    logic        timeout_hit;

    logic        ack_c;
    logic        wait_c;
    logic        drive_c;
    logic [31:0] data_c;

    // Wrap-around makes addresses below BASE_ADDR huge, so one compare
    // rejects both ends of the window.
    assign off      = bus.bus_in - BASE_ADDR;
    assign in_range = off < MEM_WORDS;

    // Fires in the WAIT cycle whose increment brings the counter to the
    // limit, so bus_wait is high for exactly WAIT_TIMEOUT cycles.
    assign timeout_hit = (32'(wait_cnt) + 32'd1) == WAIT_TIMEOUT;

    always_comb begin
        state_nxt  = state;
        addr_cycle = 1'b0;
        ack_c      = 1'b0;
        wait_c     = 1'b0;
        drive_c    = 1'b0;
        data_c     = 32'h0;
        mem_re     = 1'b0;
        mem_addr   = addr_q;
        case (state)
            S_IDLE: begin
                if (bus.bus_req) state_nxt = S_GRANT;
            end
            S_GRANT: begin
                ack_c = 1'b1;
                if (!bus.bus_req) begin
                    addr_cycle = 1'b1;
                    state_nxt  = S_WAIT;
                    if (in_range) begin
                        mem_re   = 1'b1;
                        mem_addr = off[15:0];
                    end
                end
            end
            S_WAIT: begin
                wait_c = !have_data;
                if (have_data) state_nxt = S_DATA;
            end
            S_DATA: begin
                drive_c   = 1'b1;
                data_c    = data_q;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                drive_c   = 1'b1;
                data_c    = data_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            have_data <= 1'b0;
            err_txn   <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= 8'h0;
            data_q    <= 32'h0;
            addr_q    <= 16'h0;
        end else begin
            state <= state_nxt;

            if (addr_cycle) begin
                addr_q   <= off[15:0];
                wait_cnt <= 8'h0;
                if (!in_range) begin
                    // Error answer is ready at once: no bus_wait at all.
                    data_q    <= ERR_WORD;
                    have_data <= 1'b1;
                    err_txn   <= 1'b1;
                end else begin
                    err_txn <= 1'b0;
                end
            end else if (state == S_WAIT) begin
                if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
                if (!have_data) begin
                    if (mem_rvalid) begin
                        data_q    <= mem_rdata;
                        have_data <= 1'b1;
                    end else if (timeout_hit) begin
                        data_q    <= ERR_WORD;
                        have_data <= 1'b1;
                        err_txn   <= 1'b1;
                    end
                end
            end else if (state == S_HOLD) begin
                have_data <= 1'b0;
                err_txn   <= 1'b0;
            end

            // Set on the WAIT->DATA edge of an error transaction; set beats clear.
            if (state == S_WAIT && have_data && err_txn) err <= 1'b1;
            else if (err_clr)                               err <= 1'b0;
        end
    end

    assign bus.bus_ack   = ack_c;
    assign bus.bus_wait  = wait_c;
    assign bus.bus_drive = drive_c;
    assign bus.bus_data  = data_c;
    assign dbg_state     = state;

endmodule

// File: tb/tb_vga_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_vga_bus_responder
//   Directed bench for vga_bus_responder. Each transaction is described by
//   its address, grant length and memory latency; the bench derives the
//   per-cycle expected outputs from those and queues them for a compare
//   process that checks every cycle. Per-transaction literal checks pin the
//   headline numbers (strobe count, wait length, data word, err).
// ---------------------------------------------------------------------------
module tb_vga_bus_responder;

    localparam logic [31:0] BASE    = 32'h00001050;
    localparam int unsigned WORDS   = 19200;
    localparam int          TMO     = 255;
    localparam logic [31:0] ERR_W   = 32'hDEADBEEF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_bus_responder_if bus();
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        err;
    logic        err_clr;
    logic [2:0]  dbg_state;

    vga_bus_responder dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .err        (err),
        .err_clr    (err_clr),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        ack;
        logic        wt;
        logic        drv;
        logic [31:0] data;
        logic        re;
        logic        chk_addr;
        logic [15:0] addr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: sticky error and last latched word address.
    logic        err_m  = 1'b0;
    logic [15:0] addr_m = 16'h0;

    // Observed totals per transaction.
    int          cnt_re, cnt_wait, cnt_drive;
    logic [31:0] drv_data;
    logic [15:0] re_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] off);
        return 32'hA5A5_0000 | {16'h0, off[15:0]};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (bus.bus_wait)  cnt_wait++;
            if (mem_re)        begin cnt_re++; re_addr = mem_addr; end
            if (bus.bus_drive) begin cnt_drive++; drv_data = bus.bus_data; end
            if (dbg_state > 3'd1) check("ack_outside_grant", 32'(bus.bus_ack), 32'd0);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("bus_ack",   32'(bus.bus_ack),   32'(e.ack));
                check("bus_wait",  32'(bus.bus_wait),  32'(e.wt));
                check("bus_drive", 32'(bus.bus_drive), 32'(e.drv));
                check("bus_data",  bus.bus_data,       e.data);
                check("mem_re",    32'(mem_re),        32'(e.re));
                check("err",       32'(err),           32'(e.err));
                if (e.chk_addr) check("mem_addr", 32'(mem_addr), 32'(e.addr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic exp_t idle_exp();
        exp_t e;
        e          = '0;
        e.chk_addr = 1'b1;
        e.addr     = addr_m;
        e.err      = err_m;
        return e;
    endfunction

    task automatic cyc(input logic req, input logic rv, input logic [31:0] rd,
                       input logic clr, input exp_t e);
        @(posedge clk);
        #1;
        bus.bus_req = req;
        mem_rvalid  = rv;
        mem_rdata   = rd;
        err_clr     = clr;
        exp_q.push_back(e);
    endtask

    task automatic clear_counts();
        cnt_re = 0; cnt_wait = 0; cnt_drive = 0; drv_data = 32'h0; re_addr = 16'hFFFF;
    endtask

    // One read. g = grant cycles (req still high for g-1 of them), lat = memory
    // latency in cycles after mem_re (0 = never answers). Cycle 0 is the IDLE
    // cycle with req high; cycle g is the address cycle.
    task automatic run_txn(input logic [31:0] addr, input int g, input int lat,
                           input bit req_hold, input bit clr_at_set, input bit late_rv,
                           input int stop_at);
        logic [31:0] off, dexp;
        bit          inr, tmo, etx;
        int          n_wait, total, w;
        exp_t        e;
        logic        req, rv, clr;
        logic [31:0] rd;
        off    = addr - BASE;
        inr    = off < WORDS;
        tmo    = inr && (lat == 0 || lat > TMO);
        n_wait = !inr ? 1 : (tmo ? TMO + 1 : lat + 1);
        etx    = !inr || tmo;
        dexp   = etx ? ERR_W : mem_word(off);
        total  = 1 + g + n_wait + 2;
        bus.bus_in = addr;
        clear_counts();
        for (int c = 0; c < total; c++) begin
            if (stop_at >= 0 && c == stop_at) return;
            e = idle_exp(); req = (c < g); rv = 1'b0; rd = 32'h0; clr = 1'b0;
            if (c >= 1 && c <= g) e.ack = 1'b1;
            if (c == g) begin
                if (inr) begin e.re = 1'b1; e.addr = off[15:0]; end
                else e.chk_addr = 1'b0;
            end
            if (c > g && c <= g + n_wait) begin
                w = c - g - 1;
                e.wt = (w < n_wait - 1);
                if (inr && !tmo && w == lat - 1) begin rv = 1'b1; rd = mem_word(off); end
                if (late_rv && w == n_wait - 1) begin rv = 1'b1; rd = 32'h1234_5678; end
                if (clr_at_set && w == n_wait - 1) clr = 1'b1;
            end
            if (c > g + n_wait) begin
                e.drv = 1'b1; e.data = dexp;
                if (late_rv) begin rv = 1'b1; rd = 32'h8765_4321; end
                if (req_hold && c == total - 1) req = 1'b1;
            end
            cyc(req, rv, rd, clr, e);
            if (c == g) addr_m = off[15:0];
            if (c == g + n_wait && etx) err_m = 1'b1;
            else if (clr)               err_m = 1'b0;
        end
    endtask

    task automatic idle(input int n, input int clr_at);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = idle_exp();
            cyc(1'b0, 1'b0, 32'h0, (i == clr_at), e);
            if (i == clr_at) err_m = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b0;
        bus.bus_req = 1'b0;
        bus.bus_in  = 32'h0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        err_clr     = 1'b0;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",   32'(bus.bus_ack),   32'd0);
        check("rst_drive", 32'(bus.bus_drive), 32'd0);
        check("rst_data",  bus.bus_data,       32'd0);
        check("rst_addr",  32'(mem_addr),      32'd0);
        check("rst_err",   32'(err),           32'd0);
        reset = 1'b1;
        idle(2, -1);

        // Nominal read, 1-cycle memory, two grant cycles.
        run_txn(32'h0000_1051, 2, 1, 0, 0, 1, -1);
        settle();
        check("nom_re_cnt",    cnt_re,     1);
        check("nom_re_addr",   32'(re_addr), 32'd1);
        check("nom_wait_cnt",  cnt_wait,   1);
        check("nom_drive_cnt", cnt_drive,  2);
        check("nom_data",      drv_data,   32'hA5A5_0001);
        check("nom_err",       32'(err),   32'd0);
        idle(2, -1);

        // Slow memory, 10-cycle latency.
        run_txn(BASE + 32'd100, 1, 10, 0, 0, 0, -1);
        settle();
        check("slow_wait_cnt", cnt_wait, 10);
        check("slow_data",     drv_data, 32'hA5A5_0064);
        check("slow_err",      32'(err), 32'd0);
        idle(1, -1);

        // Last valid word.
        run_txn(BASE + 32'd19199, 1, 2, 0, 0, 0, -1);
        settle();
        check("top_data", drv_data, 32'hA5A5_4AFF);
        idle(1, -1);

        // Below base (wraps) and one past the top.
        run_txn(32'h0000_1040, 1, 1, 0, 0, 1, -1);
        settle();
        check("low_re_cnt",   cnt_re,   0);
        check("low_wait_cnt", cnt_wait, 0);
        check("low_data",     drv_data, ERR_W);
        check("low_err",      32'(err), 32'd1);
        idle(3, 0);
        run_txn(BASE + 32'd19200, 2, 1, 0, 0, 0, -1);
        settle();
        check("high_re_cnt",   cnt_re,   0);
        check("high_wait_cnt", cnt_wait, 0);
        check("high_data",     drv_data, ERR_W);
        check("high_err",      32'(err), 32'd1);
        idle(3, 1);
        settle();
        check("clr_err", 32'(err), 32'd0);

        // Error set and err_clr together: set wins.
        run_txn(32'h0000_0000, 1, 1, 0, 1, 0, -1);
        settle();
        check("prio_err", 32'(err), 32'd1);
        idle(2, 0);

        // Memory never answers.
        run_txn(BASE + 32'd7, 1, 0, 0, 0, 0, -1);
        settle();
        check("tmo_wait_cnt", cnt_wait, 255);
        check("tmo_data",     drv_data, ERR_W);
        check("tmo_err",      32'(err), 32'd1);
        idle(3, 1);
        settle();
        check("tmo_clr_err", 32'(err), 32'd0);

        // Reset in the middle of WAIT.
        run_txn(BASE + 32'd5, 1, 0, 0, 0, 0, 5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ack",   32'(bus.bus_ack),   32'd0);
        check("mid_rst_wait",  32'(bus.bus_wait),  32'd0);
        check("mid_rst_drive", 32'(bus.bus_drive), 32'd0);
        check("mid_rst_data",  bus.bus_data,       32'd0);
        check("mid_rst_re",    32'(mem_re),        32'd0);
        check("mid_rst_addr",  32'(mem_addr),      32'd0);
        err_m  = 1'b0;
        addr_m = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, idle_exp());
        idle(1, -1);
        run_txn(BASE + 32'd9, 2, 1, 0, 0, 0, -1);
        settle();
        check("post_rst_re_cnt", cnt_re,   1);
        check("post_rst_data",   drv_data, 32'hA5A5_0009);
        idle(1, -1);

        // Back-to-back: request re-raised during HOLD.
        run_txn(BASE + 32'd2, 1, 1, 1, 0, 0, -1);
        run_txn(BASE + 32'd3, 1, 3, 0, 0, 0, -1);
        settle();
        check("b2b_data",     drv_data, 32'hA5A5_0003);
        check("b2b_wait_cnt", cnt_wait, 3);
        idle(2, -1);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
